// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : restoring divider with a start/busy/done handshake,
//               one quotient bit per clock, MSB first.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
   parameter int NDD = 11,
   parameter int NDV = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [NDD-1:0] dividend,
   input  logic [NDV-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic [NDD-1:0] quotient,
   output logic [NDV-1:0] remainder,
   output logic           div_by_zero
);

   localparam int            CW       = $clog2(NDD);
   localparam logic [CW-1:0] CNT_LAST = CW'(NDD - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [NDD-1:0] d_q, d_d;
   logic [NDV-1:0] v_q, v_d;
   logic [NDV-1:0] r_q, r_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [NDD-1:0] quot_q, quot_d;
   logic [NDV-1:0] rem_q, rem_d;
   logic           dbz_q, dbz_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [NDV:0]   trial;
   logic           trial_ge;
   logic [NDV-1:0] trial_sub;
   logic [NDV-1:0] step_r;
   logic [NDD-1:0] step_d;

   // The running remainder always stays below V, so a subtraction done at
   // NDV bits is exact whenever the trial value is not smaller than V.
   assign trial     = {r_q, d_q[NDD-1]};
   assign trial_ge  = (trial >= {1'b0, v_q});
   assign trial_sub = trial[NDV-1:0] - v_q;
   assign step_r    = trial_ge ? trial_sub : trial[NDV-1:0];
   assign step_d    = {d_q[NDD-2:0], trial_ge};

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      v_d     = v_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               d_d   = dividend;
               v_d   = divisor;
               r_d   = '0;
               cnt_d = '0;
               if (divisor == '0) begin
                  state_d = S_DONE;
                  quot_d  = '1;
                  rem_d   = '0;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = S_RUN;
                  dbz_d   = 1'b0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            d_d   = step_d;
            r_d   = step_r;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               quot_d  = step_d;
               rem_d   = step_r;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         v_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         v_q     <= v_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// tb_seq_divider : self-checking bench for seq_divider (vector table,
//                  scoreboard queue, hand-written corner sequences).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

   localparam int NDD = 11;
   localparam int NDV = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [NDD-1:0] dividend = '0;
   logic [NDV-1:0] divisor = '0;
   logic           busy;
   logic           done;
   logic [NDD-1:0] quotient;
   logic [NDV-1:0] remainder;
   logic           div_by_zero;

   seq_divider #(.NDD(NDD), .NDV(NDV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NDD-1:0] q;
      logic [NDV-1:0] r;
      logic           dbz;
   } exp_t;

   typedef struct {
      logic [NDD-1:0] dd;
      logic [NDV-1:0] dv;
      logic [NDD-1:0] q;
      logic [NDV-1:0] r;
      logic           dbz;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [NDD-1:0] q, input logic [NDV-1:0] r, input logic dbz);
      exp_t e;
      e.q   = q;
      e.r   = r;
      e.dbz = dbz;
      sb.push_back(e);
   endtask

   // Every done pulse retires the oldest expected result.
   always @(negedge clk) begin
      if (rst_n && done === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_done: got done=1, want no pending operation");
         end else begin
            mon_e = sb.pop_front();
            chk("quotient", 32'(quotient), 32'(mon_e.q));
            chk("remainder", 32'(remainder), 32'(mon_e.r));
            chk("div_by_zero", 32'(div_by_zero), 32'(mon_e.dbz));
         end
      end
   end

   task automatic wait_done(input string name, output int k);
      bit seen;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 30) begin
         @(negedge clk);
         k++;
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no done in 30 cycles, want done", name);
         if (sb.size() > 0) void'(sb.pop_back());
      end
   endtask

   task automatic run_op(input logic [NDD-1:0] dd, input logic [NDV-1:0] dv,
                         input logic [NDD-1:0] eq, input logic [NDV-1:0] er, input logic edbz);
      int  k;
      int  nbusy;
      bit  seen;
      @(negedge clk);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      push_exp(eq, er, edbz);
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = NDD'($urandom);
      divisor  = NDV'($urandom);
      seen  = 1'b0;
      nbusy = 0;
      k     = 0;
      while (!seen && k < 30) begin
         @(negedge clk);
         k++;
         if (k == 1 && dv != 0) chk("dbz_clear_on_start", 32'(div_by_zero), 32'd0);
         if (done === 1'b1) seen = 1'b1;
         if (busy === 1'b1) nbusy++;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL op_timeout: got no done for %0d/%0d, want done", dd, dv);
         if (sb.size() > 0) void'(sb.pop_back());
      end else begin
         chk("latency", 32'(k), (dv == 0) ? 32'd1 : 32'd12);
         chk("busy_cycles", 32'(nbusy), (dv == 0) ? 32'd0 : 32'd11);
      end
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
   endtask

   vec_t        vecs[10];
   int          kk;
   int          ndone;
   int unsigned a, b, dd_i, dv_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation still running, want finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{dd: 11'd100,  dv: 6'd7,  q: 11'd14,    r: 6'd2,  dbz: 1'b0};
      vecs[1] = '{dd: 11'd2047, dv: 6'd63, q: 11'd32,    r: 6'd31, dbz: 1'b0};
      vecs[2] = '{dd: 11'd2047, dv: 6'd1,  q: 11'd2047,  r: 6'd0,  dbz: 1'b0};
      vecs[3] = '{dd: 11'd5,    dv: 6'd9,  q: 11'd0,     r: 6'd5,  dbz: 1'b0};
      vecs[4] = '{dd: 11'd0,    dv: 6'd5,  q: 11'd0,     r: 6'd0,  dbz: 1'b0};
      vecs[5] = '{dd: 11'd5,    dv: 6'd0,  q: 11'h7FF,   r: 6'd0,  dbz: 1'b1};
      vecs[6] = '{dd: 11'd12,   dv: 6'd4,  q: 11'd3,     r: 6'd0,  dbz: 1'b0};
      vecs[7] = '{dd: 11'd1024, dv: 6'd32, q: 11'd32,    r: 6'd0,  dbz: 1'b0};
      vecs[8] = '{dd: 11'd63,   dv: 6'd63, q: 11'd1,     r: 6'd0,  dbz: 1'b0};
      vecs[9] = '{dd: 11'd62,   dv: 6'd63, q: 11'd0,     r: 6'd62, dbz: 1'b0};

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r, vecs[i].dbz);

      // start pulsed mid-run with new operands must not disturb the op
      @(negedge clk);
      start = 1'b1; dividend = 11'd100; divisor = 6'd7;
      push_exp(11'd14, 6'd2, 1'b0);
      @(posedge clk); #1;
      start = 1'b0; dividend = 11'd0; divisor = 6'd0;
      repeat (3) @(negedge clk);
      start = 1'b1; dividend = 11'd50; divisor = 6'd5;
      @(negedge clk);
      start = 1'b0; dividend = 11'd999; divisor = 6'd1;
      wait_done("ignored_start", kk);
      @(negedge clk);

      // start held high: re-accepted in the DONE cycle
      @(negedge clk);
      start = 1'b1; dividend = 11'd12; divisor = 6'd4;
      push_exp(11'd3, 6'd0, 1'b0);
      wait_done("held_start_first", kk);
      dividend = 11'd2047; divisor = 6'd63;
      push_exp(11'd32, 6'd31, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done_low", 32'(done), 32'd0);
      wait_done("held_start_second", kk);
      @(negedge clk);

      // asynchronous reset in the middle of a run
      @(negedge clk);
      start = 1'b1; dividend = 11'd100; divisor = 6'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_quotient", 32'(quotient), 32'd0);
      chk("arst_remainder", 32'(remainder), 32'd0);
      chk("arst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("no_done_after_reset", 32'(ndone), 32'd0);
      run_op(11'd36, 6'd6, 11'd6, 6'd0, 1'b0);

      // random operands, half of them exact multiplier products
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 1) begin
            b    = $urandom_range(63, 1);
            a    = $urandom_range(2047 / b, 0);
            dd_i = a * b;
         end else begin
            dd_i = $urandom_range(2047, 0);
         end
         dv_i = (i % 2 == 1) ? b : $urandom_range(63, 1);
         run_op(NDD'(dd_i), NDV'(dv_i), NDD'(dd_i / dv_i), NDV'(dd_i % dv_i), 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
